// File: rtl/mem_rmw_if.sv
// Transfer-size package and request/response/memory bus for mem_rmw_ctrl.
// Defining MEM_RMW_LOAD_SIGNEXT_EN adds req_signed to the request side.
package mem_rmw_pkg;
  typedef enum logic [1:0] {BYTE = 2'd0, HALFWORD = 2'd1, WORD = 2'd2} tsize_e;
endpackage

interface mem_rmw_if #(
  parameter int unsigned N = 1024
);
  import mem_rmw_pkg::*;
  localparam int unsigned AW = $clog2(N);

  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  tsize_e        req_tsize;
  logic [31:0]   req_wdata;
`ifdef MEM_RMW_LOAD_SIGNEXT_EN
  logic          req_signed;
`endif
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_error;
  logic [AW-1:0] mem_address;
  tsize_e        mem_tsize;
  logic          mem_write;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_data;
  logic          mem_rerror;

  // Controller side.
  modport slave (
`ifdef MEM_RMW_LOAD_SIGNEXT_EN
    input  req_signed,
`endif
    input  req_valid, req_write, req_addr, req_tsize, req_wdata, resp_ready, mem_data, mem_rerror,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_address, mem_tsize, mem_write, mem_write_data
  );

  // Requester plus memory side.
  modport master (
`ifdef MEM_RMW_LOAD_SIGNEXT_EN
    output req_signed,
`endif
    output req_valid, req_write, req_addr, req_tsize, req_wdata, resp_ready, mem_data, mem_rerror,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_address, mem_tsize, mem_write, mem_write_data
  );
endinterface

// File: rtl/mem_rmw_ctrl.sv
// Load/store controller that turns sub-word stores into read-modify-write of a word memory.
// Optional MEM_RMW_LOAD_SIGNEXT_EN enables signed byte/halfword loads via req_signed.
module mem_rmw_ctrl
  import mem_rmw_pkg::*;
#(
  parameter int unsigned N = 1024
) (
  input  logic     clk,
  input  logic     rst,
  mem_rmw_if.slave bus
);
  localparam int unsigned AW = $clog2(N);

  typedef enum logic [2:0] {StIdle, StRd, StRmw, StWr, StResp} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q;
  tsize_e        tsize_q;
  logic [31:0]   wdata_q;
  logic          write_q;
`ifdef MEM_RMW_LOAD_SIGNEXT_EN
  logic          signed_q;
`endif
  logic [31:0]   old_q;
  logic [31:0]   rdata_q;
  logic          error_q;

  logic          accept;
  logic          misaligned;
  logic [31:0]   load_data;
  logic [31:0]   merged;

  assign accept     = bus.req_valid & bus.req_ready;
  assign misaligned = ((bus.req_tsize == WORD) && (bus.req_addr[1:0] != 2'b00)) ||
                      ((bus.req_tsize == HALFWORD) && bus.req_addr[0]);

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!bus.req_write)            state_d = StRd;
          else if (misaligned)           state_d = StResp;
          else if (bus.req_tsize == WORD) state_d = StWr;
          else                           state_d = StRmw;
        end
      end
      StRd:   state_d = StResp;
      StRmw:  state_d = StWr;
      StWr:   state_d = StResp;
      StResp: if (bus.resp_valid && bus.resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory returns sub-word loads right-aligned and zero-extended.
  always_comb begin
    load_data = bus.mem_data;
`ifdef MEM_RMW_LOAD_SIGNEXT_EN
    if (signed_q) begin
      if (tsize_q == BYTE)          load_data = {{24{bus.mem_data[7]}}, bus.mem_data[7:0]};
      else if (tsize_q == HALFWORD) load_data = {{16{bus.mem_data[15]}}, bus.mem_data[15:0]};
    end
`endif
  end

  always_comb begin
    merged = old_q;
    if (tsize_q == BYTE)          merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else if (tsize_q == HALFWORD) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else                          merged = wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      tsize_q  <= BYTE;
      wdata_q  <= '0;
      write_q  <= 1'b0;
`ifdef MEM_RMW_LOAD_SIGNEXT_EN
      signed_q <= 1'b0;
`endif
      old_q    <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            addr_q   <= bus.req_addr;
            tsize_q  <= bus.req_tsize;
            wdata_q  <= bus.req_wdata;
            write_q  <= bus.req_write;
`ifdef MEM_RMW_LOAD_SIGNEXT_EN
            signed_q <= bus.req_signed;
`endif
            rdata_q  <= '0;
            error_q  <= bus.req_write & misaligned;
          end
        end
        StRd: begin
          rdata_q <= load_data;
          error_q <= bus.mem_rerror;
        end
        StRmw:   old_q   <= bus.mem_data;
        StWr:    error_q <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_ready      = 1'b0;
    bus.mem_address    = addr_q;
    bus.mem_tsize      = WORD;
    bus.mem_write      = 1'b0;
    bus.mem_write_data = merged;
    bus.resp_valid     = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.req_ready   = !rst;
        bus.mem_address = bus.req_addr;
        bus.mem_tsize   = bus.req_tsize;
      end
      StRd:  bus.mem_tsize = tsize_q;
      StRmw: ;
      StWr: begin
        // Reset in this cycle must suppress the write.
        bus.mem_write   = write_q & !rst;
        bus.mem_address = {addr_q[AW-1:2], 2'b00};
      end
      StResp:  bus.resp_valid = !rst;
      default: ;
    endcase
  end

  assign bus.resp_rdata = rst ? '0 : rdata_q;
  assign bus.resp_error = rst ? 1'b0 : error_q;
endmodule
